// File: rtl/riscv_fetch_queue.sv
// Fetch stage: PC generator, one-deep request tracking against a 1-cycle imem, and a prefetch FIFO.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module riscv_fetch_queue #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_re,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_delivered,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]   fetch_pc;
  logic              inflight_vld_p1;
  logic [PC_W-1:0]   inflight_pc_p1;
  logic [INST_W-1:0] fifo_inst [DEPTH];
  logic [PC_W-1:0]   fifo_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic              unused_redirect_lsb;

  // Outstanding request counts as occupied so a returning response always has a slot.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_vld_p1);
  assign issue     = !rst && !stall && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
  assign push      = inflight_vld_p1 && !redirect_valid;
  assign out_valid = !rst && (count != '0) && !stall;
  assign pop       = out_valid && out_ready;

  assign imem_re   = issue;
  assign imem_addr = fetch_pc;
  assign out_inst  = out_valid ? fifo_inst[rd_ptr] : NOP_INST;
  assign out_pc    = out_valid ? fifo_pc[rd_ptr] : '0;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Stage p0 -> p1: PC generation, request tracking and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc        <= RESET_PC;
      inflight_vld_p1 <= 1'b0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
    end else if (redirect_valid) begin
      fetch_pc        <= {redirect_pc[PC_W-1:2], 2'b00};
      inflight_vld_p1 <= 1'b0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + PC_W'(4);
      inflight_vld_p1 <= issue;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p1 -> FIFO: response data captured alongside the PC that requested it.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc_p1 <= fetch_pc;
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= inflight_pc_p1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_delivered <= '0;
      perf_flushed   <= '0;
    end else begin
      if (pop)            perf_delivered <= perf_delivered + 32'd1;
      if (redirect_valid) perf_flushed   <= perf_flushed + 32'(occupancy);
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: per-cycle vector table plus a redirect-with-pop sequence.
module tb_riscv_fetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_re;
  logic [31:0] imem_addr, imem_rdata, out_inst, out_pc;
  logic        out_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_delivered, perf_flushed;
`endif

  int checks   = 0;
  int failures = 0;

  riscv_fetch_queue #(.PC_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_re(imem_re), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_delivered(perf_delivered), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_re) imem_rdata <= imem_addr ^ KEY;
  end

  typedef struct {
    logic        rst, stall, rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        re;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] opc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic re, input logic [31:0] addr,
                     input logic ov, input logic [31:0] opc);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.re = re; v.addr = addr; v.ov = ov; v.opc = opc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, got, exp);
    end
  endtask

  initial begin
    int n;
    // Streaming from reset with consumer always ready.
    add(1,0,0,0,1, 0,32'h0,0,0);
    add(0,0,0,0,1, 1,32'h0,0,0);
    add(0,0,0,0,1, 1,32'h4,0,0);
    for (int k = 2; k <= 5; k++) add(0,0,0,0,1, 1,32'(4*k),1,32'(4*(k-2)));
    add(1,0,0,0,1, 0,32'h18,0,0);
    // Consumer not ready: fill to full, then drain.
    add(0,0,0,0,0, 1,32'h0,0,0);
    add(0,0,0,0,0, 1,32'h4,0,0);
    add(0,0,0,0,0, 1,32'h8,1,32'h0);
    add(0,0,0,0,0, 1,32'hC,1,32'h0);
    add(0,0,0,0,0, 0,32'h10,1,32'h0);
    add(0,0,0,0,0, 0,32'h10,1,32'h0);
    add(0,0,0,0,1, 0,32'h10,1,32'h0);
    add(0,0,0,0,1, 1,32'h10,1,32'h4);
    add(0,0,0,0,1, 1,32'h14,1,32'h8);
    add(0,0,0,0,1, 1,32'h18,1,32'hC);
    add(0,0,0,0,1, 1,32'h1C,1,32'h10);
    add(0,0,0,0,1, 1,32'h20,1,32'h14);
    add(1,0,0,0,1, 0,32'h24,0,0);
    // Redirect with count=3, inflight=1; then stall on a returning response.
    add(0,0,0,0,0, 1,32'h0,0,0);
    add(0,0,0,0,0, 1,32'h4,0,0);
    add(0,0,0,0,0, 1,32'h8,1,32'h0);
    add(0,0,0,0,0, 1,32'hC,1,32'h0);
    add(0,0,1,32'h203,0, 0,32'h10,1,32'h0);
    add(0,0,0,0,1, 1,32'h200,0,0);
    add(0,0,0,0,1, 1,32'h204,0,0);
    add(0,0,0,0,1, 1,32'h208,1,32'h200);
    add(0,0,0,0,1, 1,32'h20C,1,32'h204);
    add(0,1,0,0,1, 0,32'h210,0,0);
    add(0,0,0,0,1, 1,32'h210,1,32'h208);
    add(0,0,0,0,1, 1,32'h214,1,32'h20C);
    add(0,0,0,0,1, 1,32'h218,1,32'h210);
    // Redirect during stall; issue starts when stall drops.
    add(0,1,1,32'h400,1, 0,32'h21C,0,0);
    add(0,1,0,0,1, 0,32'h400,0,0);
    add(0,0,0,0,1, 1,32'h400,0,0);
    add(0,0,0,0,1, 1,32'h404,0,0);
    add(0,0,0,0,1, 1,32'h408,1,32'h400);
    // Ten pops, then redirect with count=2, inflight=1.
    add(1,0,0,0,1, 0,32'h40C,0,0);
    add(0,0,0,0,1, 1,32'h0,0,0);
    add(0,0,0,0,1, 1,32'h4,0,0);
    for (int k = 2; k <= 11; k++) add(0,0,0,0,1, 1,32'(4*k),1,32'(4*(k-2)));
    add(0,0,0,0,0, 1,32'h30,1,32'h28);
    add(0,0,1,32'h100,0, 0,32'h34,1,32'h28);
    add(0,0,0,0,1, 1,32'h100,0,0);

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; stall = vecs[i].stall; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      @(negedge clk);
      chk("imem_re",   i, 32'(imem_re),   32'(vecs[i].re));
      chk("imem_addr", i, imem_addr,      vecs[i].addr);
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
      chk("out_pc",    i, out_pc,         vecs[i].ov ? vecs[i].opc : 32'h0);
      chk("out_inst",  i, out_inst,       vecs[i].ov ? (vecs[i].opc ^ KEY) : NOP);
      @(posedge clk);
      #1;
    end

`ifdef FETCH_PERF_CNT_EN
    chk("perf_delivered", 0, perf_delivered, 32'd10);
    chk("perf_flushed",   0, perf_flushed,   32'd3);
`endif

    // Redirect in the same cycle as a pop: the head is still presented, then flushed.
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    redirect_valid = 1'b1; redirect_pc = 32'h81;
    @(negedge clk);
    chk("pop_at_redir_valid", 0, 32'(out_valid), 32'd1);
    chk("pop_at_redir_pc",    0, out_pc,         32'h8);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("post_redir_valid", 0, 32'(out_valid), 32'd0);
    chk("post_redir_re",    0, 32'(imem_re),   32'd1);
    chk("post_redir_addr",  0, imem_addr,      32'h80);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 10);
    chk("redir_latency", 0, 32'(n), 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk("redir_seq_pc",   k, out_pc,   32'h80 + 32'(4*k));
      chk("redir_seq_inst", k, out_inst, (32'h80 + 32'(4*k)) ^ KEY);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
